// File: rtl/jogo_pkg.sv
// jogo_pkg: shared types and constants for the memory game input stage
package jogo_pkg;
  localparam int LARGURA_JOGADA = 4;
  localparam int DEBOUNCE_PADRAO = 3;
  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    ESTAB_PRESS = 3'd1,
    PRESSIONADO = 3'd2,
    ESTAB_SOLTA = 3'd3,
    INVALIDA    = 3'd4
  } estado_detector_t;
endpackage

// File: rtl/detector_jogada_if.sv
// detector_jogada_if: switch inputs and play-event outputs between controller and detector
interface detector_jogada_if;
  logic [jogo_pkg::LARGURA_JOGADA-1:0] chaves;
  logic                                habilita;
  logic [jogo_pkg::LARGURA_JOGADA-1:0] jogada;
  logic                                jogada_feita;
  logic                                jogada_invalida;
  logic                                tem_jogada;
  logic [2:0]                          db_estado;
  modport master(output chaves, habilita, input jogada, jogada_feita, jogada_invalida, tem_jogada, db_estado);
  modport slave(input chaves, habilita, output jogada, jogada_feita, jogada_invalida, tem_jogada, db_estado);
endinterface

// File: rtl/sincronizador_2ff.sv
// sincronizador_2ff: two-flop synchroniser for asynchronous inputs, async active-low reset
module sincronizador_2ff #(
  parameter int LARGURA = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);
  logic [LARGURA-1:0] meta_q, sinc_q;
  // shift the raw input through two flops to settle metastability
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      meta_q <= '0;
      sinc_q <= '0;
    end else begin
      meta_q <= d;
      sinc_q <= meta_q;
    end
  assign q = sinc_q;
endmodule

// File: rtl/detector_jogada.sv
// detector_jogada: debounce switches and emit one event per press; DETECTOR_JOGADA_ONEHOT_EN rejects multi-key codes
module detector_jogada
  import jogo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_PADRAO
) (
  input logic         clock,
  input logic         reset,
  detector_jogada_if.slave bus
);
  localparam int LC = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [LC-1:0] CONT_MAX = LC'(DEBOUNCE_CYCLES - 1);
  logic [LARGURA_JOGADA-1:0] chaves_s;
  estado_detector_t estado_q, estado_d;
  logic [LARGURA_JOGADA-1:0] candidato_q, candidato_d, jogada_q, jogada_d;
  logic [LC-1:0] cont_q, cont_d;
  logic feita_q, feita_d, invalida_q, invalida_d, valido;
  sincronizador_2ff #(.LARGURA(LARGURA_JOGADA)) u_sinc (
    .clock(clock),
    .reset(reset),
    .d    (bus.chaves),
    .q    (chaves_s)
  );
`ifdef DETECTOR_JOGADA_ONEHOT_EN
  assign valido = $onehot(candidato_q);
`else
  assign valido = 1'b1;
`endif
  // next state: press stabilisation, hold, release stabilisation
  always_comb begin
    estado_d    = estado_q;
    candidato_d = candidato_q;
    cont_d      = cont_q;
    jogada_d    = jogada_q;
    feita_d     = 1'b0;
    invalida_d  = 1'b0;
    case (estado_q)
      OCIOSO:
        if (chaves_s != '0) begin
          estado_d    = ESTAB_PRESS;
          candidato_d = chaves_s;
          cont_d      = '0;
        end
      ESTAB_PRESS:
        if (chaves_s == '0) estado_d = OCIOSO;
        else if (chaves_s != candidato_q) begin
          candidato_d = chaves_s;
          cont_d      = '0;
        end else if (cont_q == CONT_MAX) begin
          estado_d   = valido ? PRESSIONADO : INVALIDA;
          feita_d    = valido & bus.habilita;
          invalida_d = ~valido & bus.habilita;
          jogada_d   = (valido & bus.habilita) ? candidato_q : jogada_q;
        end else cont_d = cont_q + LC'(1);
      PRESSIONADO, INVALIDA:
        if (chaves_s == '0) begin
          estado_d = ESTAB_SOLTA;
          cont_d   = '0;
        end
      ESTAB_SOLTA:
        if (chaves_s != '0) estado_d = PRESSIONADO;
        else if (cont_q == CONT_MAX) estado_d = OCIOSO;
        else cont_d = cont_q + LC'(1);
      default: estado_d = OCIOSO;
    endcase
  end
  // state, counter and registered event outputs
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      estado_q    <= OCIOSO;
      candidato_q <= '0;
      cont_q      <= '0;
      jogada_q    <= '0;
      feita_q     <= 1'b0;
      invalida_q  <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      candidato_q <= candidato_d;
      cont_q      <= cont_d;
      jogada_q    <= jogada_d;
      feita_q     <= feita_d;
      invalida_q  <= invalida_d;
    end
  assign bus.jogada          = jogada_q;
  assign bus.jogada_feita    = feita_q;
  assign bus.jogada_invalida = invalida_q;
  assign bus.tem_jogada      = estado_q inside {PRESSIONADO, ESTAB_SOLTA, INVALIDA};
  assign bus.db_estado       = estado_q;
endmodule

// File: tb/tb_detector_jogada.sv
// tb_detector_jogada: scoreboard bench for detector_jogada against a run-length reference model
module tb_detector_jogada;
  import jogo_pkg::*;
  localparam int D = DEBOUNCE_PADRAO;
  typedef struct packed {logic inv; logic [3:0] cod;} ev_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  detector_jogada_if bus();
  detector_jogada #(.DEBOUNCE_CYCLES(D)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  int compared = 0, mismatched = 0;
  int cyc = 0, n_feita = 0, n_inv = 0, t_feita = 0;
  ev_t q[$];
  logic [3:0] d1, d2, run_val, m_jogada;
  bit held;
  int run_len, zero_len;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  function automatic bit valido(input logic [3:0] c);
`ifdef DETECTOR_JOGADA_ONEHOT_EN
    return $countones(c) == 1;
`else
    return c != 4'd0;
`endif
  endfunction

  always @(posedge clock) cyc++;

  // reference: a press is a run of D+1 identical nonzero synchronised samples, a release D+1 zero samples
  always @(posedge clock or negedge reset)
    if (!reset) begin
      d1 = 0; d2 = 0; held = 0; run_val = 0; run_len = 0; zero_len = 0; m_jogada = 0;
      q.delete();
    end else begin
      logic [3:0] s;
      s = d2;
      d2 = d1;
      d1 = bus.chaves;
      if (!held) begin
        if (s == 0) run_len = 0;
        else if (run_len > 0 && s == run_val) run_len++;
        else begin run_val = s; run_len = 1; end
        if (run_len == D + 1) begin
          held = 1; zero_len = 0; run_len = 0;
          if (bus.habilita) begin
            if (valido(run_val)) begin m_jogada = run_val; q.push_back({1'b0, run_val}); end
            else q.push_back({1'b1, run_val});
          end
        end
      end else begin
        zero_len = (s == 0) ? zero_len + 1 : 0;
        if (zero_len == D + 1) begin held = 0; run_len = 0; end
      end
    end

  // monitor: pop the expected event whenever the DUT pulses
  always @(negedge clock)
    if (reset) begin
      chk("tem_jogada", bus.tem_jogada, held);
      chk("jogada", bus.jogada, m_jogada);
      if (bus.jogada_feita || bus.jogada_invalida) begin
        if (bus.jogada_feita) begin n_feita++; t_feita = cyc; end
        if (bus.jogada_invalida) n_inv++;
        if (q.size() == 0) chk("pulse_unexpected", {bus.jogada_feita, bus.jogada_invalida}, 0);
        else begin
          ev_t e;
          e = q.pop_front();
          chk("pulse_kind", {bus.jogada_feita, bus.jogada_invalida}, {!e.inv, e.inv});
          if (!e.inv) chk("pulse_code", bus.jogada, e.cod);
        end
      end
      if (q.size() != 0) begin
        chk("pulse_missing", 0, q.size());
        q.delete();
      end
    end

  task automatic aplica(input logic [3:0] v, input int n);
    bus.chaves = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic chk_reset_outs();
    chk("rst_jogada", bus.jogada, 0);
    chk("rst_feita", bus.jogada_feita, 0);
    chk("rst_invalida", bus.jogada_invalida, 0);
    chk("rst_tem", bus.tem_jogada, 0);
    chk("rst_estado", bus.db_estado, 0);
  endtask

  initial begin
    int f0, i0, c0;
    bus.chaves = 0;
    bus.habilita = 1;
    repeat (2) @(negedge clock);
    chk_reset_outs();
    reset = 1;
    repeat (2) @(negedge clock);
    f0 = n_feita; c0 = cyc;
    aplica(4'b0001, 10);
    chk("clean_estado", bus.db_estado, 2);
    aplica(4'b0000, 10);
    chk("clean_count", n_feita - f0, 1);
    chk("clean_latency", t_feita - c0, D + 3);
    chk("clean_jogada", bus.jogada, 4'b0001);
    chk("clean_idle", bus.db_estado, 0);
    f0 = n_feita;
    repeat (3) begin aplica(4'b0010, 1); aplica(4'b0000, 1); end
    aplica(4'b0010, 10);
    aplica(4'b0000, 10);
    chk("bounce_count", n_feita - f0, 1);
    chk("bounce_jogada", bus.jogada, 4'b0010);
    f0 = n_feita;
    aplica(4'b0100, D);
    aplica(4'b0000, 10);
    chk("short_count", n_feita - f0, 0);
    chk("short_jogada", bus.jogada, 4'b0010);
    f0 = n_feita;
    aplica(4'b1000, D + 1);
    aplica(4'b0000, 10);
    chk("minw_count", n_feita - f0, 1);
    chk("minw_jogada", bus.jogada, 4'b1000);
    f0 = n_feita; i0 = n_inv;
    bus.habilita = 0;
    aplica(4'b0001, 8);
    aplica(4'b0000, 10);
    bus.habilita = 1;
    chk("gate_count", n_feita - f0, 0);
    chk("gate_jogada", bus.jogada, 4'b1000);
    aplica(4'b0011, 8);
    aplica(4'b0000, 10);
`ifdef DETECTOR_JOGADA_ONEHOT_EN
    chk("multi_inv", n_inv - i0, 1);
    chk("multi_jogada", bus.jogada, 4'b1000);
`else
    chk("multi_feita", n_feita - f0, 1);
    chk("multi_jogada", bus.jogada, 4'b0011);
`endif
    aplica(4'b0100, 8);
    #2 reset = 0;
    #1 chk_reset_outs();
    @(negedge clock);
    reset = 1;
    f0 = n_feita;
    aplica(4'b0100, 10);
    chk("after_rst_count", n_feita - f0, 1);
    chk("after_rst_jogada", bus.jogada, 4'b0100);
    aplica(4'b0000, 10);
    repeat (300) begin
      logic [3:0] v;
      v = 4'($urandom_range(0, 15));
      bus.habilita = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 4)) begin aplica(v, 1); aplica(0, 1); end
      aplica(v, $urandom_range(1, 8));
      if ($urandom_range(0, 3) == 0) aplica(4'($urandom_range(1, 15)), $urandom_range(1, 3));
      aplica(4'b0000, $urandom_range(1, 9));
    end
    aplica(4'b0000, 12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
